// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes a subset of RV32I ALU instructions at acceptance and
// buffers them in a main entry plus a skid entry ahead of the ALU.
package alu_pkg;
  typedef enum logic [1:0] {
    ADD_OP = 2'd0,
    SUB_OP = 2'd1,
    AND_OP = 2'd2,
    OR_OP  = 2'd3
  } alu_op_e;
endpackage

module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_instr_valid,
  output logic                  o_instr_ready,
  input  logic [31:0]           i_instr,
  input  logic [DATA_WIDTH-1:0] i_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_rs2_data,
  output logic                  o_alu_valid,
  input  logic                  i_alu_ready,
  output logic [DATA_WIDTH-1:0] o_elemA,
  output logic [DATA_WIDTH-1:0] o_elemB,
  output alu_op_e               o_op,
  output logic [4:0]            o_rd,
  output logic                  o_illegal,
  output logic [7:0]            o_illegal_cnt
);

  logic                  dec_legal_s;
  alu_op_e               dec_op_s;
  logic [DATA_WIDTH-1:0] dec_elem_b_s;

  logic                  accept_s;
  logic                  consume_s;
  logic                  take_s;
  logic                  main_valid_nxt_s;
  logic                  skid_valid_nxt_s;
  logic                  load_main_new_s;
  logic                  load_main_skid_s;
  logic                  load_skid_s;

  logic                  main_valid_r;
  logic [DATA_WIDTH-1:0] main_a_r;
  logic [DATA_WIDTH-1:0] main_b_r;
  alu_op_e               main_op_r;
  logic [4:0]            main_rd_r;
  logic                  skid_valid_r;
  logic [DATA_WIDTH-1:0] skid_a_r;
  logic [DATA_WIDTH-1:0] skid_b_r;
  alu_op_e               skid_op_r;
  logic [4:0]            skid_rd_r;
  logic                  instr_ready_r;
  logic                  illegal_r;
  logic [7:0]            illegal_cnt_r;

  // The rs1 index is resolved by the register file upstream.
  logic unused_s;
  assign unused_s = ^i_instr[19:15];

  assign accept_s  = i_instr_valid & instr_ready_r;
  assign consume_s = main_valid_r & i_alu_ready;
  assign take_s    = accept_s & dec_legal_s;

  // Decode the offered instruction into operation and second operand.
  always_comb begin
    dec_legal_s  = 1'b0;
    dec_op_s     = ADD_OP;
    dec_elem_b_s = i_rs2_data;
    case (i_instr[6:0])
      7'b0110011: begin
        if (i_instr[31:25] == 7'b0000000) begin
          case (i_instr[14:12])
            3'b000:  begin dec_legal_s = 1'b1; dec_op_s = ADD_OP; end
            3'b111:  begin dec_legal_s = 1'b1; dec_op_s = AND_OP; end
            3'b110:  begin dec_legal_s = 1'b1; dec_op_s = OR_OP;  end
            default: begin dec_legal_s = 1'b0; dec_op_s = ADD_OP; end
          endcase
        end else if ((i_instr[31:25] == 7'b0100000) && (i_instr[14:12] == 3'b000)) begin
          dec_legal_s = 1'b1;
          dec_op_s    = SUB_OP;
        end else begin
          dec_legal_s = 1'b0;
        end
      end
      7'b0010011: begin
        dec_elem_b_s = DATA_WIDTH'($signed(i_instr[31:20]));
        case (i_instr[14:12])
          3'b000:  begin dec_legal_s = 1'b1; dec_op_s = ADD_OP; end
          3'b111:  begin dec_legal_s = 1'b1; dec_op_s = AND_OP; end
          3'b110:  begin dec_legal_s = 1'b1; dec_op_s = OR_OP;  end
          default: begin dec_legal_s = 1'b0; dec_op_s = ADD_OP; end
        endcase
      end
      default: begin
        dec_legal_s = 1'b0;
      end
    endcase
  end

  // Route accepted entries between main and skid; skid always drains first.
  always_comb begin
    main_valid_nxt_s = main_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    load_main_new_s  = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (skid_valid_r) begin
      if (consume_s) begin
        load_main_skid_s = 1'b1;
        skid_valid_nxt_s = 1'b0;
      end else begin
        skid_valid_nxt_s = 1'b1;
      end
    end else if (!main_valid_r || consume_s) begin
      main_valid_nxt_s = take_s;
      load_main_new_s  = take_s;
    end else begin
      skid_valid_nxt_s = take_s;
      load_skid_s      = take_s;
    end
  end

  // Entry valid flags and the registered ready.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_valid_r  <= 1'b0;
      skid_valid_r  <= 1'b0;
      instr_ready_r <= 1'b1;
    end else begin
      main_valid_r  <= main_valid_nxt_s;
      skid_valid_r  <= skid_valid_nxt_s;
      instr_ready_r <= ~skid_valid_nxt_s;
    end
  end

  // Main entry payload; only changes on a load so it is stable while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_a_r  <= {DATA_WIDTH{1'b0}};
      main_b_r  <= {DATA_WIDTH{1'b0}};
      main_op_r <= ADD_OP;
      main_rd_r <= 5'd0;
    end else if (load_main_skid_s) begin
      main_a_r  <= skid_a_r;
      main_b_r  <= skid_b_r;
      main_op_r <= skid_op_r;
      main_rd_r <= skid_rd_r;
    end else if (load_main_new_s) begin
      main_a_r  <= i_rs1_data;
      main_b_r  <= dec_elem_b_s;
      main_op_r <= dec_op_s;
      main_rd_r <= i_instr[11:7];
    end
  end

  // Skid entry payload.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      skid_a_r  <= {DATA_WIDTH{1'b0}};
      skid_b_r  <= {DATA_WIDTH{1'b0}};
      skid_op_r <= ADD_OP;
      skid_rd_r <= 5'd0;
    end else if (load_skid_s) begin
      skid_a_r  <= i_rs1_data;
      skid_b_r  <= dec_elem_b_s;
      skid_op_r <= dec_op_s;
      skid_rd_r <= i_instr[11:7];
    end
  end

  // Illegal pulse and saturating reject counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      illegal_r     <= 1'b0;
      illegal_cnt_r <= 8'd0;
    end else if (accept_s && !dec_legal_s) begin
      illegal_r <= 1'b1;
      if (illegal_cnt_r != 8'hFF) begin
        illegal_cnt_r <= illegal_cnt_r + 8'd1;
      end
    end else begin
      illegal_r <= 1'b0;
    end
  end

  assign o_instr_ready = instr_ready_r;
  assign o_alu_valid   = main_valid_r;
  assign o_elemA       = main_a_r;
  assign o_elemB       = main_b_r;
  assign o_op          = main_op_r;
  assign o_rd          = main_rd_r;
  assign o_illegal     = illegal_r;
  assign o_illegal_cnt = illegal_cnt_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_alu_issue_stage;
  import alu_pkg::*;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_instr_valid;
  logic          o_instr_ready;
  logic [31:0]   i_instr;
  logic [DW-1:0] i_rs1_data;
  logic [DW-1:0] i_rs2_data;
  logic          o_alu_valid;
  logic          i_alu_ready;
  logic [DW-1:0] o_elemA;
  logic [DW-1:0] o_elemB;
  alu_op_e       o_op;
  logic [4:0]    o_rd;
  logic          o_illegal;
  logic [7:0]    o_illegal_cnt;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready),
    .i_instr(i_instr), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .o_alu_valid(o_alu_valid), .i_alu_ready(i_alu_ready),
    .o_elemA(o_elemA), .o_elemB(o_elemB), .o_op(o_op), .o_rd(o_rd),
    .o_illegal(o_illegal), .o_illegal_cnt(o_illegal_cnt)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    alu_op_e       op;
    logic [4:0]    rd;
  } exp_t;

  typedef struct {
    logic [31:0]   instr;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    bit            legal;
    alu_op_e       op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [4:0]    rd;
  } vec_t;

  exp_t q[$];
  int   exp_cnt = 0;
  bit   exp_ill = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of the supported instructions, straight from the ISA.
  function automatic void ref_decode(input logic [31:0] ins, input logic [DW-1:0] r1,
                                     input logic [DW-1:0] r2, output bit legal, output exp_t e);
    int imm;
    legal = 1'b0;
    e.a = r1; e.b = r2; e.op = ADD_OP; e.rd = ins[11:7];
    if (ins[6:0] == 7'h33) begin
      if (ins[31:25] == 7'h00 && ins[14:12] == 3'd0) begin legal = 1'b1; e.op = ADD_OP; end
      if (ins[31:25] == 7'h20 && ins[14:12] == 3'd0) begin legal = 1'b1; e.op = SUB_OP; end
      if (ins[31:25] == 7'h00 && ins[14:12] == 3'd7) begin legal = 1'b1; e.op = AND_OP; end
      if (ins[31:25] == 7'h00 && ins[14:12] == 3'd6) begin legal = 1'b1; e.op = OR_OP;  end
    end else if (ins[6:0] == 7'h13) begin
      imm = int'(ins[31:20]);
      if (imm > 2047) imm = imm - 4096;
      e.b = DW'(imm);
      if (ins[14:12] == 3'd0) begin legal = 1'b1; e.op = ADD_OP; end
      if (ins[14:12] == 3'd7) begin legal = 1'b1; e.op = AND_OP; end
      if (ins[14:12] == 3'd6) begin legal = 1'b1; e.op = OR_OP;  end
    end
  endfunction

  task automatic check_state();
    chk("alu_valid", 64'(o_alu_valid), 64'(q.size() > 0));
    chk("instr_ready", 64'(o_instr_ready), 64'(q.size() < 2));
    chk("illegal", 64'(o_illegal), 64'(exp_ill));
    chk("illegal_cnt", 64'(o_illegal_cnt), 64'(exp_cnt));
    if (q.size() > 0) begin
      chk("elemA", 64'(o_elemA), 64'(q[0].a));
      chk("elemB", 64'(o_elemB), 64'(q[0].b));
      chk("op", 64'(o_op), 64'(q[0].op));
      chk("rd", 64'(o_rd), 64'(q[0].rd));
    end
  endtask

  // One clock: check model vs DUT, drive inputs, advance model on the handshakes.
  task automatic step(input bit v, input logic [31:0] ins, input logic [DW-1:0] r1,
                      input logic [DW-1:0] r2, input bit rdy);
    bit   acc, cons, legal;
    exp_t e;
    check_state();
    i_instr_valid = v; i_instr = ins; i_rs1_data = r1; i_rs2_data = r2; i_alu_ready = rdy;
    acc  = v && (q.size() < 2);
    cons = rdy && (q.size() > 0);
    ref_decode(ins, r1, r2, legal, e);
    @(posedge clk);
    if (cons) void'(q.pop_front());
    if (acc && legal) q.push_back(e);
    exp_ill = acc && !legal;
    if (exp_ill && exp_cnt < 255) exp_cnt++;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int k;
    ins = $urandom;
    k = $urandom_range(0, 9);
    ins[6:0] = (k < 4) ? 7'h33 : (k < 8) ? 7'h13 : 7'($urandom);
    if ($urandom_range(0, 3) != 0) begin
      k = $urandom_range(0, 2);
      ins[14:12] = (k == 0) ? 3'd0 : (k == 1) ? 3'd6 : 3'd7;
    end
    k = $urandom_range(0, 9);
    if (ins[6:0] == 7'h33 && k < 6) ins[31:25] = 7'h00;
    else if (ins[6:0] == 7'h33 && k < 9) ins[31:25] = 7'h20;
    return ins;
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] ins;
    bit legal;
    exp_t e;
    for (int t = 0; t < 100; t++) begin
      ins = rand_instr();
      ref_decode(ins, 32'd0, 32'd0, legal, e);
      if (legal) return ins;
    end
    return 32'h002081B3;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    int   pulses, seen_valid, nvalid;

    tbl[0]  = '{32'h002081B3, 32'd5,       32'd7,      1'b1, ADD_OP, 32'd5,       32'd7,        5'd3};
    tbl[1]  = '{32'hFFF00293, 32'd0,       32'h1234,   1'b1, ADD_OP, 32'd0,       32'hFFFFFFFF, 5'd5};
    tbl[2]  = '{32'h402081B3, 32'd9,       32'd3,      1'b1, SUB_OP, 32'd9,       32'd3,        5'd3};
    tbl[3]  = '{32'h0020F233, 32'hF0F0,    32'hFF00,   1'b1, AND_OP, 32'hF0F0,    32'hFF00,     5'd4};
    tbl[4]  = '{32'h0020E333, 32'd1,       32'd2,      1'b1, OR_OP,  32'd1,       32'd2,        5'd6};
    tbl[5]  = '{32'h0F00F393, 32'hABCD,    32'h9999,   1'b1, AND_OP, 32'hABCD,    32'h000000F0, 5'd7};
    tbl[6]  = '{32'h80016413, 32'h77,      32'h1,      1'b1, OR_OP,  32'h77,      32'hFFFFF800, 5'd8};
    tbl[7]  = '{32'h00209133, 32'd1,       32'd2,      1'b0, ADD_OP, 32'd0,       32'd0,        5'd0};
    tbl[8]  = '{32'h4020F233, 32'd1,       32'd2,      1'b0, ADD_OP, 32'd0,       32'd0,        5'd0};
    tbl[9]  = '{32'h00109093, 32'd1,       32'd2,      1'b0, ADD_OP, 32'd0,       32'd0,        5'd0};
    tbl[10] = '{32'h00000000, 32'd1,       32'd2,      1'b0, ADD_OP, 32'd0,       32'd0,        5'd0};
    tbl[11] = '{32'h00000013, 32'h55,      32'h66,     1'b1, ADD_OP, 32'h55,      32'd0,        5'd0};

    rst_n = 1'b0; i_instr_valid = 1'b0; i_instr = 32'd0;
    i_rs1_data = 32'd0; i_rs2_data = 32'd0; i_alu_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_alu_valid", 64'(o_alu_valid), 64'd0);
    chk("rst_instr_ready", 64'(o_instr_ready), 64'd1);
    chk("rst_illegal", 64'(o_illegal), 64'd0);
    chk("rst_illegal_cnt", 64'(o_illegal_cnt), 64'd0);
    chk("rst_elemA", 64'(o_elemA), 64'd0);
    chk("rst_elemB", 64'(o_elemB), 64'd0);
    chk("rst_op", 64'(o_op), 64'(ADD_OP));
    chk("rst_rd", 64'(o_rd), 64'd0);

    // Vector table, one instruction per cycle with the consumer always ready.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].instr, tbl[i].rs1, tbl[i].rs2, 1'b1);
      chk("tbl_valid", 64'(o_alu_valid), 64'(tbl[i].legal));
      chk("tbl_illegal", 64'(o_illegal), 64'(!tbl[i].legal));
      if (tbl[i].legal) begin
        chk("tbl_op", 64'(o_op), 64'(tbl[i].op));
        chk("tbl_elemA", 64'(o_elemA), 64'(tbl[i].a));
        chk("tbl_elemB", 64'(o_elemB), 64'(tbl[i].b));
        chk("tbl_rd", 64'(o_rd), 64'(tbl[i].rd));
      end
    end
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);

    // Skid fill under backpressure, then drain in order.
    step(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b0);
    step(1'b1, 32'h402081B3, 32'd9, 32'd3, 1'b0);
    chk("skid_ready_low", 64'(o_instr_ready), 64'd0);
    chk("skid_main_add", 64'(o_op), 64'(ADD_OP));
    step(1'b1, 32'h0020E333, 32'd1, 32'd1, 1'b0);
    chk("skid_hold_op", 64'(o_op), 64'(ADD_OP));
    chk("skid_hold_a", 64'(o_elemA), 64'd5);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    chk("skid_second_sub", 64'(o_op), 64'(SUB_OP));
    chk("skid_second_valid", 64'(o_alu_valid), 64'd1);
    chk("skid_ready_back", 64'(o_instr_ready), 64'd1);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    chk("skid_drained", 64'(o_alu_valid), 64'd0);

    // Asynchronous reset with both entries full.
    step(1'b1, 32'h002081B3, 32'd1, 32'd2, 1'b0);
    step(1'b1, 32'h402081B3, 32'd3, 32'd4, 1'b0);
    check_state();
    i_instr_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(o_alu_valid), 64'd0);
    chk("async_rst_ready", 64'(o_instr_ready), 64'd1);
    chk("async_rst_cnt", 64'(o_illegal_cnt), 64'd0);
    q.delete(); exp_cnt = 0; exp_ill = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 300 illegal instructions saturate the counter.
    pulses = 0; seen_valid = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 32'h00000000, 32'd1, 32'd2, 1'b1);
      pulses += int'(o_illegal);
      seen_valid += int'(o_alu_valid);
    end
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    chk("illegal_pulses", 64'(pulses), 64'd300);
    chk("illegal_no_valid", 64'(seen_valid), 64'd0);
    chk("illegal_cnt_sat", 64'(o_illegal_cnt), 64'hFF);

    // Sixteen back-to-back legal operations without bubbles.
    nvalid = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, rand_legal(), 32'($urandom), 32'($urandom), 1'b1);
      nvalid += int'(o_alu_valid);
    end
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    chk("b2b_outputs", 64'(nvalid), 64'd16);

    // Random traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), rand_instr(), 32'($urandom), 32'($urandom),
           ($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    check_state();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
